// File: rtl/riscv_pkg.sv
// Shared core types for the writeback path: datapath widths, arbiter state
// encoding and the writeback request payload.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int STARVE_W = 4;

  typedef enum logic [0:0] {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_out_reg.sv
// Registered writeback stage: captures the granted payload one cycle after
// the handshake and suppresses writes to x0.
module wb_out_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            xfer_i,
  input  wb_req_t         req_i,
  output logic            we_o,
  output logic [RA_W-1:0] rd_o,
  output logic [XLEN-1:0] data_o
);

  logic    we_q;
  wb_req_t req_q;

  // Write enable pulses for the cycle after each accepted non-x0 transfer.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
    end else begin
      we_q <= xfer_i && (req_i.rd != '0);
    end
  end

  // Payload holds the last accepted request between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (xfer_i) begin
      req_q <= req_i;
    end
  end

  assign we_o   = we_q;
  assign rd_o   = req_q.rd;
  assign data_o = req_q.data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter for the register-file write port. Loads have fixed
// priority; an ALU request denied STARVE_MAX times in a row gets one forced
// grant. Datapath widths come from riscv_pkg (XLEN, RA_W).
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_MAX = 3   // legal 1..15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            alu_forced
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C  = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_LAST_C = STARVE_W'(STARVE_MAX - 1);

  arb_state_t           state_q, state_d;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic                 alu_xfer, mem_xfer, alu_denied;
  wb_req_t              wb_req;

  // Grant decode: priority follows the state, readies held low in reset.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (rst_n) begin
      if (state_q == PRI_MEM) begin
        mem_ready = mem_valid;
        alu_ready = alu_valid && !mem_valid;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid && !alu_valid;
      end
    end
  end

  assign alu_xfer   = alu_valid && alu_ready;
  assign mem_xfer   = mem_valid && mem_ready;
  assign alu_denied = alu_valid && !alu_ready;

  // Payload select for whichever requester transfers this cycle.
  always_comb begin
    wb_req.rd   = mem_rd;
    wb_req.data = mem_data;
    if (alu_xfer) begin
      wb_req.rd   = alu_rd;
      wb_req.data = alu_data;
    end
  end

  // Starvation counter: counts consecutive ALU denials, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_valid || alu_xfer) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX_C) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Priority FSM: the last tolerated denial flips priority so the ALU wins
  // next cycle; priority returns to loads once the ALU is served or leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRI_MEM: if (alu_denied && starve_cnt_q == STARVE_LAST_C) state_d = PRI_ALU;
      PRI_ALU: if (alu_xfer || !alu_valid) state_d = PRI_MEM;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PRI_MEM;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign alu_forced = (state_q == PRI_ALU);

  wb_out_reg u_wb_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .xfer_i (alu_xfer || mem_xfer),
    .req_i  (wb_req),
    .we_o   (wb_we),
    .rd_o   (wb_rd),
    .data_o (wb_data)
  );

  // Grants are exclusive, and a pending ALU request is never denied more
  // than STARVE_MAX times in a row.
  assert property (@(posedge clk) disable iff (!rst_n) !(alu_ready && mem_ready));
  assert property (@(posedge clk) disable iff (!rst_n) alu_denied |-> (starve_cnt_q < STARVE_MAX_C));

endmodule
